uart_tx_framed: RTL and testbench
=================================

# uart_tx_framed

Parametrised UART transmitter with a small input FIFO, configurable frame format (data width, parity, stop bits) and an internal baud divider. Sits between on-chip producers and the TxD pad: the producer pushes words through a valid/ready handshake, and the block serialises them LSB-first with no idle gap between queued frames. It supersedes the fixed 8N2, single-word transmitter.

## Interface
- `DATA_BITS`, 8: data bits per frame; legal range 5..8.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: legal values 1 or 2.
- `CLKS_PER_BIT`, 217: clock cycles per bit period (25 MHz / 115200). A value of 1 gives one bit per clock, for simulation.
- `FIFO_DEPTH`, 4: entries; must be a power of two, ≥ 2.
- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `tx_data`  in  DATA_BITS: word to send.
- `tx_valid`  in  1: producer offers `tx_data`.
- `tx_ready`  out  1: FIFO can accept; equals !full.
- `tx`  out  1: serial line; idles high.
- `busy`  out  1: high when the FIFO is non-empty or a frame is in progress.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **Push.** A push occurs on any edge where `tx_valid && tx_ready`. `tx_data` is captured on that edge and need not be held afterwards.
- **Full FIFO.** `tx_valid` while full is ignored; the producer must hold the word until `tx_ready` returns.
- **Simultaneous push and pop.** Occupancy is unchanged. Because `tx_ready` is !full, a full FIFO never pushes, even in a pop cycle.
- **FSM states:** IDLE, START, DATA, PAR, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register and go to START. Otherwise stay.
  - START: `tx` = 0 for one bit period, then DATA.
  - DATA: `tx` = shift[0] for each bit period, shifting right after each. After DATA_BITS periods go to PAR if PARITY≠0, else STOP.
  - PAR: `tx` = XOR of the data bits, inverted for odd parity. One bit period, then STOP.
  - STOP: `tx` = 1 for STOP_BITS periods. On the last cycle, if the FIFO is non-empty, pop and go directly to START (back-to-back frames). Otherwise go to IDLE.
- **Parity computation.** Parity is computed from the word as it is loaded, not from the shifted value.
- **Bit counter.** The baud counter counts 0..CLKS_PER_BIT-1. It is reset at every state entry and wraps at the bit boundary, which advances the bit index or changes state. It runs only outside IDLE.
- **Frame length.** (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- **Unused bits.** Data bits above DATA_BITS are not present. No sign or zero extension occurs.
- **Reset values.** `tx` = 1, `tx_ready` = 1, `busy` = 0, `fifo_count` = 0. FSM goes to IDLE, counters to 0.
- **Reset mid-frame.** The frame is aborted and `tx` is high on the edge after reset. FIFO contents are discarded. No partial frame resumes.
- **Illegal parameters.** DATA_BITS outside 5..8, STOP_BITS ∉ {1,2}, PARITY > 2, or a non-power-of-two FIFO_DEPTH must fail elaboration.

## Timing
- **`tx` is registered.** It has no combinational path from any input.
- **Push to start bit.** For a push on edge N into an empty FIFO with the FSM idle:
  - `fifo_count` = 1 after N.
  - Pop on N+1.
  - `tx` = 0 from N+2 for CLKS_PER_BIT cycles.
- **`busy`.** Rises after edge N. It falls on the same edge that ends the final stop bit, provided the FIFO is empty.
- **`tx_ready`.** Deasserts on the edge where `fifo_count` reaches FIFO_DEPTH. It reasserts on the edge after the pop.
- **Back-to-back frames.** Between the last stop bit and the next start bit, the gap is zero cycles.

## Structure
- **Shared package `uart_pkg`.**
  - Parity encoding constants: PAR_NONE, PAR_ODD, PAR_EVEN.
  - FSM state typedef.
  - Default CLKS_PER_BIT for 25 MHz / 115200.
  - This package is shared with the future receiver.
- **Sub-module `uart_sync_fifo`.**
  - Parameters: width, depth.
  - Ports: push, pop, full, empty, count.
  - The serialiser FSM and baud counter stay in the top module.

## Test plan
- **Reset.** Reset for 3 cycles → `tx` = 1, `tx_ready` = 1, `busy` = 0, `fifo_count` = 0.
- **Single frame 8N1.** CLKS_PER_BIT = 4, push 0xA5 → from N+2, `tx` = 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles; `busy` low after 40 cycles.
- **7E2.** DATA_BITS = 7, PARITY = 2, STOP_BITS = 2, CLKS_PER_BIT = 1, push 0x53 → `tx` = 0,1,1,0,0,1,0,1,0,1,1 (parity bit 0), then idle high.
- **Full FIFO.** Hold `tx_valid` high with 5 words, FIFO_DEPTH = 4 → four accepted; `tx_ready` low; the fifth is accepted only after the first pop. All five frames are sent contiguously with no idle cycle between stop and start.
- **Reset mid-frame.** Assert `rst` during bit 3 of 0xFF with 2 words queued → `tx` = 1 next edge, `fifo_count` = 0, and no further transitions on `tx`.
- **Odd parity.** PARITY = 1, push 0x00 → parity bit = 1. Push 0x01 → parity bit = 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, serialiser states, default baud divider.
// Shared by the transmitter and the receiver so both sides agree on frame encoding.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // 25 MHz core clock at 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 217;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } uartState_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a combinational head read; pushes and pops take effect on the edge.
// A push while full or a pop while empty is ignored, so callers may drive push/pop freely.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         popData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign doPush  = push && !full;
    assign doPop   = pop && !empty;
    assign popData = mem[rdPtr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/uart_tx_framed.sv
// Buffered UART transmitter: start bit appears two edges after a push into an idle block,
// queued frames follow back-to-back; tx_ready drops while the input FIFO is full.
module uart_tx_framed
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int   CW      = $clog2(CLKS_PER_BIT + 1);
    localparam logic ODD_INV = (PARITY == PAR_ODD);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 8 || (STOP_BITS != 1 && STOP_BITS != 2) ||
            PARITY < 0 || PARITY > 2 || CLKS_PER_BIT < 1 || FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gIllegalParams
            $error("uart_tx_framed: illegal parameter combination");
        end
    endgenerate

    uartState_t           state;
    logic [DATA_BITS-1:0] shiftReg;
    logic [DATA_BITS-1:0] headData;
    logic [CW-1:0]        baudCnt;
    logic [2:0]           bitIdx;
    logic                 parityBit;
    logic                 loadParity;
    logic                 txActive;
    logic                 fifoFull;
    logic                 fifoEmpty;
    logic                 bitEnd;
    logic                 lastStop;
    logic                 loadWord;

    assign bitEnd     = (baudCnt == CW'(CLKS_PER_BIT - 1));
    assign lastStop   = (bitIdx == 3'(STOP_BITS - 1));
    assign loadWord   = !fifoEmpty && ((state == IDLE) || (state == STOP && bitEnd && lastStop));
    assign loadParity = (^headData) ^ ODD_INV;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tx_valid),
        .pushData (tx_data),
        .pop      (loadWord),
        .popData  (headData),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifo_count)
    );

    assign tx_ready = !fifoFull;
    // txActive covers the final stop bit, which tx shows one edge after the FSM leaves STOP
    assign busy     = !fifoEmpty || (state != IDLE) || txActive;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shiftReg  <= '0;
            baudCnt   <= '0;
            bitIdx    <= '0;
            parityBit <= 1'b0;
            txActive  <= 1'b0;
            tx        <= 1'b1;
        end else begin
            txActive <= (state != IDLE);
            baudCnt  <= bitEnd ? '0 : baudCnt + 1'b1;
            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    baudCnt <= '0;
                    if (loadWord) begin
                        shiftReg  <= headData;
                        parityBit <= loadParity;
                        state     <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (bitEnd) begin
                        bitIdx <= '0;
                        state  <= DATA;
                    end
                end
                DATA: begin
                    tx <= shiftReg[0];
                    if (bitEnd) begin
                        shiftReg <= shiftReg >> 1;
                        if (bitIdx == 3'(DATA_BITS - 1)) begin
                            bitIdx <= '0;
                            state  <= (PARITY != PAR_NONE) ? PAR : STOP;
                        end else begin
                            bitIdx <= bitIdx + 1'b1;
                        end
                    end
                end
                PAR: begin
                    tx <= parityBit;
                    if (bitEnd) begin
                        bitIdx <= '0;
                        state  <= STOP;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (bitEnd) begin
                        if (lastStop) begin
                            bitIdx <= '0;
                            // Chain straight into the next start bit when a word is waiting
                            if (loadWord) begin
                                shiftReg  <= headData;
                                parityBit <= loadParity;
                                state     <= START;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            bitIdx <= bitIdx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed and randomized checks of three uart_tx_framed configurations against a frame-level model.
module tb_uart_tx_framed;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A: 8N1, 4 clocks per bit
    logic [7:0] dataA;
    logic       validA, readyA, txA, busyA;
    logic [2:0] cntA;
    // Instance B: 7E2, 1 clock per bit
    logic [6:0] dataB;
    logic       validB, readyB, txB, busyB;
    logic [2:0] cntB;
    // Instance C: 8O1, 2 clocks per bit
    logic [7:0] dataC;
    logic       validC, readyC, txC, busyC;
    logic [2:0] cntC;

    uart_tx_framed #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) uA (
        .clk(clk), .rst(rst), .tx_data(dataA), .tx_valid(validA), .tx_ready(readyA),
        .tx(txA), .busy(busyA), .fifo_count(cntA));
    uart_tx_framed #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .CLKS_PER_BIT(1), .FIFO_DEPTH(4)) uB (
        .clk(clk), .rst(rst), .tx_data(dataB), .tx_valid(validB), .tx_ready(readyB),
        .tx(txB), .busy(busyB), .fifo_count(cntB));
    uart_tx_framed #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(2), .FIFO_DEPTH(4)) uC (
        .clk(clk), .rst(rst), .tx_data(dataC), .tx_valid(validC), .tx_ready(readyC),
        .tx(txC), .busy(busyC), .fifo_count(cntC));

    int cpbT[3]   = '{4, 1, 2};
    int dbT[3]    = '{8, 7, 8};
    int parT[3]   = '{0, 2, 1};
    int sbT[3]    = '{1, 2, 1};
    localparam int DEPTH = 4;

    int checks   = 0;
    int failures = 0;

    int wordQ[$];
    int acceptAt[$];
    int trTx[$], trBusy[$], trCnt[$], trRdy[$];
    int exTx[$], exBusy[$], exCnt[$], exRdy[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int probe(input int s, input int what);
        int r;
        r = 0;
        case (s)
            0: case (what) 0: r = int'(txA); 1: r = int'(busyA); 2: r = int'(cntA); default: r = int'(readyA); endcase
            1: case (what) 0: r = int'(txB); 1: r = int'(busyB); 2: r = int'(cntB); default: r = int'(readyB); endcase
            default: case (what) 0: r = int'(txC); 1: r = int'(busyC); 2: r = int'(cntC); default: r = int'(readyC); endcase
        endcase
        return r;
    endfunction

    task automatic drive(input int s, input logic v, input int w);
        validA = (s == 0) && v;
        validB = (s == 1) && v;
        validC = (s == 2) && v;
        dataA  = 8'(w);
        dataB  = 7'(w);
        dataC  = 8'(w);
    endtask

    function automatic int frameLen(input int s);
        return (1 + dbT[s] + ((parT[s] != 0) ? 1 : 0) + sbT[s]) * cpbT[s];
    endfunction

    // Bit k of a frame: start, data LSB-first, optional parity, stop bits
    function automatic int frameBit(input int s, input int w, input int k);
        int ones;
        ones = 0;
        if (k == 0) return 0;
        if (k <= dbT[s]) return (w >> (k - 1)) & 1;
        if (parT[s] != 0 && k == dbT[s] + 1) begin
            for (int i = 0; i < dbT[s]; i++) ones += (w >> i) & 1;
            return (parT[s] == 2) ? (ones % 2) : (1 - ones % 2);
        end
        return 1;
    endfunction

    // Producer: offers wordQ in order, holding each word until accepted; trace index k = after edge k
    task automatic runStream(input int s, input int nCyc, input int gapPct);
        int   idx;
        logic v;
        logic rdyBefore;
        idx = 0;
        v   = 1'b0;
        acceptAt.delete(); trTx.delete(); trBusy.delete(); trCnt.delete(); trRdy.delete();
        for (int k = 0; k < nCyc; k++) begin
            if (!v && idx < wordQ.size() && int'($urandom_range(99)) >= gapPct) v = 1'b1;
            drive(s, v, (idx < wordQ.size()) ? wordQ[idx] : 0);
            rdyBefore = probe(s, 3) != 0;
            tick();
            if (v && rdyBefore) begin
                acceptAt.push_back(k);
                idx++;
                v = 1'b0;
            end
            trTx.push_back(probe(s, 0));
            trBusy.push_back(probe(s, 1));
            trCnt.push_back(probe(s, 2));
            trRdy.push_back(probe(s, 3));
        end
        drive(s, 1'b0, 0);
    endtask

    // Each frame starts two edges after its push, or right after the previous frame if later
    task automatic buildExpected(input int s, input int nCyc);
        int L, nb, start, prevEnd, idx;
        L  = frameLen(s);
        nb = L / cpbT[s];
        exTx.delete(); exBusy.delete(); exCnt.delete(); exRdy.delete();
        for (int j = 0; j < nCyc; j++) begin
            exTx.push_back(1); exBusy.push_back(0); exCnt.push_back(0); exRdy.push_back(0);
        end
        prevEnd = 0;
        for (int i = 0; i < acceptAt.size(); i++) begin
            start = acceptAt[i] + 2;
            if (start < prevEnd) start = prevEnd;
            for (int b = 0; b < nb; b++)
                for (int c = 0; c < cpbT[s]; c++) begin
                    idx = start + b * cpbT[s] + c;
                    if (idx < nCyc) exTx[idx] = frameBit(s, wordQ[i], b);
                end
            for (int j = acceptAt[i]; j < start + L && j < nCyc; j++) exBusy[j] = 1;
            for (int j = acceptAt[i]; j < nCyc; j++) exCnt[j] = exCnt[j] + 1;
            for (int j = start - 1; j < nCyc; j++) exCnt[j] = exCnt[j] - 1;
            prevEnd = start + L;
        end
        for (int j = 0; j < nCyc; j++) exRdy[j] = (exCnt[j] < DEPTH) ? 1 : 0;
    endtask

    task automatic cmpTraces(input string tag);
        string names[4] = '{"tx", "busy", "count", "ready"};
        int bad, o, e, ov, ev;
        for (int t = 0; t < 4; t++) begin
            bad = -1; o = 0; e = 0;
            for (int j = 0; j < trTx.size(); j++) begin
                case (t)
                    0: begin ov = trTx[j];   ev = exTx[j];   end
                    1: begin ov = trBusy[j]; ev = exBusy[j]; end
                    2: begin ov = trCnt[j];  ev = exCnt[j];  end
                    default: begin ov = trRdy[j]; ev = exRdy[j]; end
                endcase
                if (bad < 0 && ov != ev) begin bad = j; o = ov; e = ev; end
            end
            checks++;
            assert (bad === -1) else begin
                failures++;
                $error("FAIL %s_%s cycle=%0d observed=%0d expected=%0d", tag, names[t], bad, o, e);
            end
        end
    endtask

    task automatic runCheck(input string tag, input int s, input int nCyc, input int gapPct);
        runStream(s, nCyc, gapPct);
        chk({tag, "_accepted"}, acceptAt.size(), wordQ.size());
        buildExpected(s, nCyc);
        cmpTraces(tag);
    endtask

    // Compare tx against a literal bit pattern, each bit held cpb cycles from trace index 2
    task automatic chkPattern(input string tag, input int s, input int pat[$]);
        int bad, o;
        bad = -1; o = 0;
        for (int b = 0; b < pat.size(); b++)
            for (int c = 0; c < cpbT[s]; c++)
                if (bad < 0 && trTx[2 + b * cpbT[s] + c] != pat[b]) begin
                    bad = 2 + b * cpbT[s] + c; o = trTx[bad];
                end
        checks++;
        assert (bad === -1) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, bad, o, 1 - o);
        end
    endtask

    int lowCnt, busyCnt;

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 0);
        repeat (3) tick();
        chk("reset_tx", int'(txA), 1);
        chk("reset_ready", int'(readyA), 1);
        chk("reset_busy", int'(busyA), 0);
        chk("reset_count", int'(cntA), 0);
        chk("reset_txB", int'(txB), 1);
        chk("reset_txC", int'(txC), 1);
        rst = 1'b0;
        tick();

        // 8N1 single frame of 0xA5
        wordQ = '{8'hA5};
        runCheck("a5_8n1", 0, 50, 0);
        chk("a5_count_after_push", trCnt[0], 1);
        chk("a5_busy_after_push", trBusy[0], 1);
        chkPattern("a5_pattern", 0, '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1});
        chk("a5_busy_last_stop", trBusy[41], 1);
        chk("a5_busy_fall", trBusy[42], 0);

        // 7E2 single frame of 0x53
        wordQ = '{7'h53};
        runCheck("53_7e2", 1, 20, 0);
        chkPattern("53_pattern", 1, '{0, 1, 1, 0, 0, 1, 0, 1, 0, 1, 1});
        chk("53_idle_after", trTx[13], 1);

        // Odd parity
        wordQ = '{8'h00};
        runCheck("odd_00", 2, 30, 0);
        chk("odd_00_parity", trTx[20], 1);
        wordQ = '{8'h01};
        runCheck("odd_01", 2, 30, 0);
        chk("odd_01_parity", trTx[20], 0);

        // Producer holds valid with six words: FIFO fills, sixth waits for the second pop
        wordQ.delete();
        for (int i = 0; i < 6; i++) wordQ.push_back(int'($urandom_range(255)));
        runCheck("full_fifo", 0, 252, 0);
        chk("full_fifth_accept", acceptAt[4], 4);
        chk("full_count", trCnt[4], 4);
        chk("full_ready_low", trRdy[4], 0);
        chk("full_ready_still_low", trRdy[40], 0);
        chk("full_sixth_accept", acceptAt[5], 42);

        // Reset during data bit 3 of 0xFF with two words queued
        wordQ = '{8'hFF, int'($urandom_range(255)), int'($urandom_range(255))};
        runCheck("rst_pre", 0, 19, 0);
        chk("rst_pre_count", trCnt[18], 2);
        rst = 1'b1;
        tick();
        chk("rst_mid_tx", int'(txA), 1);
        chk("rst_mid_count", int'(cntA), 0);
        chk("rst_mid_busy", int'(busyA), 0);
        chk("rst_mid_ready", int'(readyA), 1);
        rst = 1'b0;
        lowCnt = 0;
        busyCnt = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (txA == 1'b0) lowCnt++;
            if (busyA == 1'b1) busyCnt++;
        end
        chk("rst_quiet_tx_low_cycles", lowCnt, 0);
        chk("rst_quiet_busy_cycles", busyCnt, 0);

        // Randomized streams with idle gaps on the producer side
        wordQ.delete();
        for (int i = 0; i < 12; i++) wordQ.push_back(int'($urandom_range(127)));
        runCheck("rand_7e2", 1, 300, 60);
        wordQ.delete();
        for (int i = 0; i < 10; i++) wordQ.push_back(int'($urandom_range(255)));
        runCheck("rand_8o1", 2, 320, 50);
        wordQ.delete();
        for (int i = 0; i < 6; i++) wordQ.push_back(int'($urandom_range(255)));
        runCheck("rand_8n1", 0, 450, 95);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
